// File: rtl/mode_counter.sv
// mode_counter: W-bit counter with runtime-programmable inclusive limit and four modes.
//   mode 00 up-wrap, 01 down-wrap, 10 bounce (up/down ping-pong), 11 hold.
//   Adds enable, synchronous load, a direction flag and a one-cycle terminal-count pulse.
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst       in   synchronous reset, active-high (cnt=RST_VAL, dir=1, tc=0)
//   en        in   count enable
//   load      in   synchronous load of load_val, priority over en
//   load_val  in   [W-1:0] value to load (not clamped)
//   mode      in   [1:0] counting mode
//   limit     in   [W-1:0] inclusive upper bound of the counting range
//   cnt       out  [W-1:0] registered count
//   dir       out  registered direction, 1 = up, 0 = down
//   tc        out  registered pulse on wrap or turn-around
module mode_counter #(
   parameter int unsigned W       = 3,
   parameter int unsigned RST_VAL = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic [1:0]   mode,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic         dir,
   output logic         tc
);

   typedef enum logic {
      DOWN = 1'b0,
      UP   = 1'b1
   } dir_t;

   typedef enum logic [1:0] {
      M_UP     = 2'b00,
      M_DOWN   = 2'b01,
      M_BOUNCE = 2'b10,
      M_HOLD   = 2'b11
   } mode_t;

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q, cnt_n;
   dir_t         dir_q, dir_n;
   logic         tc_q, tc_n;
   mode_t        mode_e;

   assign mode_e = mode_t'(mode);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= W'(RST_VAL);
         dir_q <= UP;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_n;
         dir_q <= dir_n;
         tc_q  <= tc_n;
      end
   end

   // Bounce mode keeps its FSM state in dir_q; the other modes force dir.
   always_comb begin
      cnt_n = cnt_q;
      dir_n = dir_q;
      tc_n  = 1'b0;
      if (load) begin
         cnt_n = load_val;
         case (mode_e)
            M_UP, M_BOUNCE: dir_n = UP;
            M_DOWN:         dir_n = DOWN;
            default:        dir_n = dir_q;
         endcase
      end else if (en && mode_e != M_HOLD) begin
         if (cnt_q > limit) begin
            // Out-of-range value (from load or a lowered limit) is pulled back silently.
            cnt_n = limit;
            case (mode_e)
               M_UP:    dir_n = UP;
               default: dir_n = DOWN;
            endcase
         end else if (limit == '0) begin
            cnt_n = '0;
            case (mode_e)
               M_UP:    dir_n = UP;
               M_DOWN:  dir_n = DOWN;
               default: dir_n = dir_q;
            endcase
         end else begin
            case (mode_e)
               M_UP: begin
                  dir_n = UP;
                  if (cnt_q == limit) begin
                     cnt_n = '0;
                     tc_n  = 1'b1;
                  end else begin
                     cnt_n = cnt_q + ONE;
                  end
               end
               M_DOWN: begin
                  dir_n = DOWN;
                  if (cnt_q == '0) begin
                     cnt_n = limit;
                     tc_n  = 1'b1;
                  end else begin
                     cnt_n = cnt_q - ONE;
                  end
               end
               default: begin
                  if (dir_q == UP) begin
                     if (cnt_q == limit) begin
                        cnt_n = limit - ONE;
                        dir_n = DOWN;
                        tc_n  = 1'b1;
                     end else begin
                        cnt_n = cnt_q + ONE;
                     end
                  end else begin
                     if (cnt_q == '0) begin
                        cnt_n = ONE;
                        dir_n = UP;
                        tc_n  = 1'b1;
                     end else begin
                        cnt_n = cnt_q - ONE;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign cnt = cnt_q;
   assign dir = dir_q;
   assign tc  = tc_q;

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: scoreboard bench for mode_counter (W=3, RST_VAL=2).
// Stimulus drives inputs on the falling edge and queues the expected
// {cnt,dir,tc} for the following rising edge; a monitor pops and compares.
module tb_mode_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [2:0] load_val = '0;
   logic [1:0] mode = 2'b00;
   logic [2:0] limit = 3'd6;
   logic [2:0] cnt;
   logic       dir;
   logic       tc;

   typedef struct {
      string      name;
      logic [2:0] cnt;
      logic       dir;
      logic       tc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   bit   done = 1'b0;

   mode_counter #(.W(3), .RST_VAL(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .limit    (limit),
      .cnt      (cnt),
      .dir      (dir),
      .tc       (tc)
   );

   always #5 clk = ~clk;

   task automatic step(input string nm, input logic r, input logic ld, input logic [2:0] lv,
                       input logic e, input logic [1:0] m, input logic [2:0] lim,
                       input logic [2:0] ec, input logic ed, input logic et);
      exp_t x;
      @(negedge clk);
      rst = r; load = ld; load_val = lv; en = e; mode = m; limit = lim;
      x.name = nm; x.cnt = ec; x.dir = ed; x.tc = et;
      sb.push_back(x);
   endtask

   // Monitor: the DUT presents a new output after every rising edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if ({cnt, dir, tc} === {x.cnt, x.dir, x.tc})
               passed++;
            else
               $display("FAIL %s: got cnt=%0d dir=%b tc=%b, expected cnt=%0d dir=%b tc=%b",
                        x.name, cnt, dir, tc, x.cnt, x.dir, x.tc);
         end
      end
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL timeout: stimulus did not complete");
         $fatal(1);
      end
   end

   initial begin
      // reset
      step("reset",      1, 0, 0, 0, 2'b00, 6, 2, 1, 0);
      step("reset_hold", 1, 0, 0, 1, 2'b00, 6, 2, 1, 0);
      // up-wrap limit 6
      step("up_load0",   0, 1, 0, 1, 2'b00, 6, 0, 1, 0);
      step("up_1",       0, 0, 0, 1, 2'b00, 6, 1, 1, 0);
      step("up_2",       0, 0, 0, 1, 2'b00, 6, 2, 1, 0);
      step("up_3",       0, 0, 0, 1, 2'b00, 6, 3, 1, 0);
      step("up_4",       0, 0, 0, 1, 2'b00, 6, 4, 1, 0);
      step("up_5",       0, 0, 0, 1, 2'b00, 6, 5, 1, 0);
      step("up_6",       0, 0, 0, 1, 2'b00, 6, 6, 1, 0);
      step("up_wrap",    0, 0, 0, 1, 2'b00, 6, 0, 1, 1);
      step("up_after",   0, 0, 0, 1, 2'b00, 6, 1, 1, 0);
      // down-wrap limit 5
      step("dn_load0",   0, 1, 0, 1, 2'b01, 5, 0, 0, 0);
      step("dn_wrap5",   0, 0, 0, 1, 2'b01, 5, 5, 0, 1);
      step("dn_4",       0, 0, 0, 1, 2'b01, 5, 4, 0, 0);
      step("dn_3",       0, 0, 0, 1, 2'b01, 5, 3, 0, 0);
      step("dn_2",       0, 0, 0, 1, 2'b01, 5, 2, 0, 0);
      step("dn_1",       0, 0, 0, 1, 2'b01, 5, 1, 0, 0);
      step("dn_0",       0, 0, 0, 1, 2'b01, 5, 0, 0, 0);
      step("dn_wrap5b",  0, 0, 0, 1, 2'b01, 5, 5, 0, 1);
      // bounce limit 3
      step("bn_load0",   0, 1, 0, 1, 2'b10, 3, 0, 1, 0);
      step("bn_1",       0, 0, 0, 1, 2'b10, 3, 1, 1, 0);
      step("bn_2",       0, 0, 0, 1, 2'b10, 3, 2, 1, 0);
      step("bn_3",       0, 0, 0, 1, 2'b10, 3, 3, 1, 0);
      step("bn_turn_dn", 0, 0, 0, 1, 2'b10, 3, 2, 0, 1);
      step("bn_1d",      0, 0, 0, 1, 2'b10, 3, 1, 0, 0);
      step("bn_0d",      0, 0, 0, 1, 2'b10, 3, 0, 0, 0);
      step("bn_turn_up", 0, 0, 0, 1, 2'b10, 3, 1, 1, 1);
      step("bn_2u",      0, 0, 0, 1, 2'b10, 3, 2, 1, 0);
      // load above limit then clamp (up-wrap)
      step("clamp_ld7",  0, 1, 7, 1, 2'b00, 4, 7, 1, 0);
      step("clamp_to4",  0, 0, 0, 1, 2'b00, 4, 4, 1, 0);
      step("clamp_wrap", 0, 0, 0, 1, 2'b00, 4, 0, 1, 1);
      step("clamp_next", 0, 0, 0, 1, 2'b00, 4, 1, 1, 0);
      // clamp in bounce forces down
      step("bclamp_ld7", 0, 1, 7, 1, 2'b10, 4, 7, 1, 0);
      step("bclamp_4",   0, 0, 0, 1, 2'b10, 4, 4, 0, 0);
      step("bclamp_3",   0, 0, 0, 1, 2'b10, 4, 3, 0, 0);
      step("bclamp_2",   0, 0, 0, 1, 2'b10, 4, 2, 0, 0);
      step("bclamp_1",   0, 0, 0, 1, 2'b10, 4, 1, 0, 0);
      step("bclamp_0",   0, 0, 0, 1, 2'b10, 4, 0, 0, 0);
      step("bclamp_turn",0, 0, 0, 1, 2'b10, 4, 1, 1, 1);
      // freeze right after a tc pulse: en low, then hold mode
      step("en0_a",      0, 0, 0, 0, 2'b10, 4, 1, 1, 0);
      step("en0_b",      0, 0, 0, 0, 2'b10, 4, 1, 1, 0);
      step("en0_c",      0, 0, 0, 0, 2'b10, 4, 1, 1, 0);
      step("hold_a",     0, 0, 0, 1, 2'b11, 4, 1, 1, 0);
      step("hold_b",     0, 0, 0, 1, 2'b11, 4, 1, 1, 0);
      step("resume",     0, 0, 0, 1, 2'b10, 4, 2, 1, 0);
      // load in hold mode keeps dir
      step("hold_ld5",   0, 1, 5, 1, 2'b11, 4, 5, 1, 0);
      step("hold_noclamp",0,0, 0, 1, 2'b11, 4, 5, 1, 0);
      // bounce entry from down-wrap starts in DOWN state
      step("entry_ld0",  0, 1, 0, 1, 2'b01, 3, 0, 0, 0);
      step("entry_turn", 0, 0, 0, 1, 2'b10, 3, 1, 1, 1);
      // reset at bounce turn point, together with load
      step("turn_ld1",   0, 1, 1, 1, 2'b01, 3, 1, 0, 0);
      step("turn_0",     0, 0, 0, 1, 2'b10, 3, 0, 0, 0);
      step("rst_load",   1, 1, 5, 1, 2'b10, 3, 2, 1, 0);
      // limit 0
      step("lim0_up_a",  0, 0, 0, 1, 2'b00, 0, 0, 1, 0);
      step("lim0_up_b",  0, 0, 0, 1, 2'b00, 0, 0, 1, 0);
      step("lim0_bn",    0, 0, 0, 1, 2'b10, 0, 0, 1, 0);
      step("lim0_dn",    0, 0, 0, 1, 2'b01, 0, 0, 0, 0);
      step("lim0_bn_dn", 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
      // full-width wrap at limit 7
      step("w_ld6",      0, 1, 6, 1, 2'b00, 7, 6, 1, 0);
      step("w_7",        0, 0, 0, 1, 2'b00, 7, 7, 1, 0);
      step("w_wrap",     0, 0, 0, 1, 2'b00, 7, 0, 1, 1);
      step("w_dn_wrap",  0, 0, 0, 1, 2'b01, 7, 7, 0, 1);
      // reset mid-count
      step("rst_mid",    1, 0, 0, 1, 2'b01, 7, 2, 1, 0);
      step("post_rst",   0, 0, 0, 1, 2'b00, 7, 3, 1, 0);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expected outputs never compared, required 0", sb.size());
      end
      done = 1'b1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
